// File: rtl/wb_intctrl.sv
// rtl/wb_intctrl.sv - Wishbone interrupt controller with level/edge sources and vectored priority output
// Optional feature: define INTCTRL_NMI_EN to make source 0 non-maskable.
module wb_intctrl #(
    parameter int NSRC     = 8,
    parameter int VECW     = 4,
    parameter int VEC_BASE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [2:0]      adr_i,
    input  logic [3:0]      sel_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    output logic            ack_o,
    input  logic [NSRC-1:0] src_i,
    input  logic            int_en_i,
    output logic [VECW-1:0] irq_o,
    output logic            irq_valid_o
);

    localparam logic [2:0] ADR_PENDING = 3'd0;
    localparam logic [2:0] ADR_MASK    = 3'd1;
    localparam logic [2:0] ADR_MODE    = 3'd2;
    localparam logic [2:0] ADR_VECTOR  = 3'd3;
    localparam logic [2:0] ADR_RAW     = 3'd4;

`ifdef INTCTRL_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif

    // Bit 0 set only when source 0 is the non-maskable source.
    localparam logic [NSRC-1:0] NMI_BITS = NSRC'(NMI_EN);

    // Replace the selected byte lanes of old_v with the matching lanes of new_v.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q,    mask_d;
    logic [NSRC-1:0] mode_q,    mode_d;
    logic [NSRC-1:0] src_q,     src_d;
    logic [VECW-1:0] irq_q,     irq_d;
    logic            ack_q,     ack_d;
    logic [31:0]     dat_q,     dat_d;

    logic            bus_req;
    logic            wr_commit;
    logic [NSRC-1:0] mask_rd;
    logic [NSRC-1:0] mask_wr;
    logic [NSRC-1:0] mode_wr;
    logic [NSRC-1:0] w1c_bits;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] cand;
    logic            nmi_hit;
    logic [31:0]     rd_word;

    // Bus handshake: sample a new request when no ack is outstanding; writes
    // take effect at the end of the ack cycle so an aborted cycle writes nothing.
    always_comb begin
        bus_req   = cyc_i & stb_i;
        ack_d     = bus_req & ~ack_q;
        wr_commit = ack_q & bus_req & we_i;
        mask_rd   = mask_q | NMI_BITS;
        mask_wr   = NSRC'(lane_merge(32'(mask_q), dat_i, sel_i));
        mode_wr   = NSRC'(lane_merge(32'(mode_q), dat_i, sel_i));
        w1c_bits  = NSRC'(lane_merge(32'd0, dat_i, sel_i));
    end

    // Read mux; read data is captured when the request is sampled and shown in the ack cycle.
    always_comb begin
        rd_word = 32'd0;
        case (adr_i)
            ADR_PENDING: rd_word = 32'(pending_q);
            ADR_MASK:    rd_word = 32'(mask_rd);
            ADR_MODE:    rd_word = 32'(mode_q);
            ADR_VECTOR:  rd_word = 32'(irq_q);
            ADR_RAW:     rd_word = 32'(src_i);
            default:     rd_word = 32'd0;
        endcase
        dat_d = (ack_d & ~we_i) ? rd_word : 32'd0;
    end

    // Configuration registers; the NMI bit of MASK is never stored.
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_commit && adr_i == ADR_MASK) begin
            mask_d = mask_wr & ~NMI_BITS;
        end
        if (wr_commit && adr_i == ADR_MODE) begin
            mode_d = mode_wr;
        end
    end

    // Pending: level bits follow the registered source, edge bits latch rising
    // edges (set beats clear), level->edge switch clears, edge->level reloads.
    always_comb begin
        src_d    = src_i;
        edge_set = src_i & ~src_q;
        clr_bits = (wr_commit && adr_i == ADR_PENDING) ? w1c_bits : '0;
        pending_d = (~mode_d & src_i)
                  | (mode_d & mode_q & (edge_set | (pending_q & ~clr_bits)));
    end

    // Priority encoder: lowest index wins, scanned so the lowest index is applied last.
    always_comb begin
        cand    = pending_q & mask_q & {NSRC{int_en_i}};
        nmi_hit = NMI_EN & pending_q[0];
        irq_d   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                irq_d = VECW'(VEC_BASE + i);
            end
        end
        if (nmi_hit) begin
            irq_d = VECW'(VEC_BASE);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            src_q     <= '0;
            irq_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    // Ack is dropped the moment the master abandons the cycle.
    always_comb begin
        ack_o       = ack_q & cyc_i & stb_i;
        dat_o       = ack_o ? dat_q : 32'd0;
        irq_o       = irq_q;
        irq_valid_o = |irq_q;
    end

endmodule

// File: tb/tb_wb_intctrl.sv
// tb/tb_wb_intctrl.sv - scoreboard testbench for wb_intctrl
module tb_wb_intctrl;

`ifdef INTCTRL_NMI_EN
    localparam logic [31:0] NMI_BIT = 32'h1;
    localparam logic [3:0]  NMI_IRQ = 4'd1;
`else
    localparam logic [31:0] NMI_BIT = 32'h0;
    localparam logic [3:0]  NMI_IRQ = 4'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_o;
    logic        ack;
    logic [7:0]  src;
    logic        int_en;
    logic [3:0]  irq;
    logic        irq_valid;

    int errors = 0;
    int checks = 0;

    string       bq_name[$];
    bit          bq_chk[$];
    logic [31:0] bq_exp[$];
    string       pq_name[$];
    logic [3:0]  pq_exp[$];
    logic        probe_r = 1'b0;
    logic        prev_ack = 1'b0;

    wb_intctrl #(.NSRC(8), .VECW(4), .VEC_BASE(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cyc_i       (cyc),
        .stb_i       (stb),
        .we_i        (we),
        .adr_i       (adr),
        .sel_i       (sel),
        .dat_i       (dat_w),
        .dat_o       (dat_o),
        .ack_o       (ack),
        .src_i       (src),
        .int_en_i    (int_en),
        .irq_o       (irq),
        .irq_valid_o (irq_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input bit w, input logic [2:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit chk, input logic [31:0] e,
                       input string nm);
        bit got;
        bq_name.push_back(nm);
        bq_chk.push_back(chk);
        bq_exp.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        tick();
        got = ack;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s ack_latency: ack=%0b required 1 one cycle after request", nm, ack);
            for (int n = 0; n < 6 && !got; n++) begin
                tick();
                got = ack;
            end
            if (!got) begin
                void'(bq_name.pop_back());
                void'(bq_chk.pop_back());
                void'(bq_exp.pop_back());
            end
        end
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        bus(1'b1, a, s, d, 1'b0, 32'd0, "write");
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        bus(1'b0, a, 4'hF, 32'd0, 1'b1, e, nm);
    endtask

    // Check irq state after the most recent edge, then advance one cycle.
    task automatic probe(input logic [3:0] e, input string nm);
        pq_name.push_back(nm);
        pq_exp.push_back(e);
        probe_r = 1'b1;
        @(negedge clk);
        #1;
        probe_r = 1'b0;
        tick();
    endtask

    // Monitor: compare bus responses and irq probes against queued expectations.
    always @(negedge clk) begin
        string       nm;
        bit          c;
        logic [31:0] e;
        logic [3:0]  ei;
        if (ack) begin
            checks++;
            if (prev_ack) begin
                errors++;
                $display("FAIL ack_single: ack high %0d consecutive cycles, required 1", 2);
            end
            if (bq_name.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ack=1 with no access outstanding, required 0");
            end else begin
                nm = bq_name.pop_front();
                c  = bq_chk.pop_front();
                e  = bq_exp.pop_front();
                if (c) begin
                    checks++;
                    if (dat_o !== e) begin
                        errors++;
                        $display("FAIL %s: dat_o=0x%08h required 0x%08h", nm, dat_o, e);
                    end
                end
            end
        end else begin
            checks++;
            if (dat_o !== 32'd0) begin
                errors++;
                $display("FAIL dat_idle: dat_o=0x%08h required 0 outside ack", dat_o);
            end
        end
        if (probe_r) begin
            if (pq_name.size() != 0) begin
                nm = pq_name.pop_front();
                ei = pq_exp.pop_front();
                checks++;
                if (irq !== ei) begin
                    errors++;
                    $display("FAIL %s: irq_o=%0d required %0d", nm, irq, ei);
                end
                checks++;
                if (irq_valid !== (ei != 4'd0)) begin
                    errors++;
                    $display("FAIL %s_valid: irq_valid_o=%0b required %0b", nm, irq_valid, (ei != 4'd0));
                end
            end
        end
        prev_ack = ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; sel = 4'd0;
        dat_w = 32'd0; src = 8'd0; int_en = 1'b0;
        tick();
        probe(4'd0, "reset_irq");
        rst = 1'b0;
        int_en = 1'b1;
        tick();
        rd(3'd0, 32'd0, "reset_pending");
        rd(3'd1, NMI_BIT, "reset_mask");
        rd(3'd2, 32'd0, "reset_mode");
        rd(3'd3, 32'd0, "reset_vector");

        // Level source 3
        wr(3'd1, 4'b0001, 32'hFF);
        src = 8'h08;
        probe(4'd0, "lvl_before");
        probe(4'd0, "lvl_lat1");
        probe(4'd4, "lvl_irq4");
        rd(3'd0, 32'h08, "lvl_pending");
        rd(3'd3, 32'd4, "lvl_vector");
        rd(3'd4, 32'h08, "lvl_raw");
        src = 8'h00;
        probe(4'd4, "lvl_drop0");
        probe(4'd4, "lvl_drop1");
        probe(4'd0, "lvl_drop2");

        // Priority
        src = 8'h60;
        tick();
        tick();
        probe(4'd6, "pri_6");
        wr(3'd1, 4'b0001, 32'hDF);
        probe(4'd6, "pri_hold");
        probe(4'd7, "pri_7");
        int_en = 1'b0;
        probe(4'd7, "pri_en_hold");
        probe(4'd0, "pri_en_off");
        int_en = 1'b1;
        src = 8'h00;

        // Edge mode on source 0
        wr(3'd1, 4'b0001, 32'hFF);
        wr(3'd2, 4'b0001, 32'h01);
        src = 8'h01;
        tick();
        src = 8'h00;
        tick();
        probe(4'd1, "edge_irq1");
        rd(3'd0, 32'h01, "edge_pending_held");
        wr(3'd0, 4'b0001, 32'h01);
        rd(3'd0, 32'h00, "edge_w1c");
        rd(3'd3, 32'h00, "edge_vector0");
        bq_name.push_back("write"); bq_chk.push_back(1'b0); bq_exp.push_back(32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; sel = 4'b0001; dat_w = 32'h01;
        tick();
        src = 8'h01;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        src = 8'h00;
        rd(3'd0, 32'h01, "edge_set_wins");
        wr(3'd0, 4'b0001, 32'h01);
        wr(3'd2, 4'b0001, 32'h00);

        // Level W1C has no effect
        src = 8'h04;
        tick();
        tick();
        wr(3'd0, 4'b0001, 32'h04);
        rd(3'd0, 32'h04, "lvl_w1c_ignored");
        src = 8'h00;

        // Bus behaviour
        wr(3'd1, 4'b0001, 32'hA5);
        rd(3'd1, 32'hA5, "bus_mask_a5");
        wr(3'd1, 4'b0010, 32'h0000FF00);
        rd(3'd1, 32'hA5, "bus_high_bits");
        wr(3'd1, 4'b1110, 32'h000000FF);
        rd(3'd1, 32'hA5, "bus_lane_unsel");
        wr(3'd6, 4'b1111, 32'hFFFFFFFF);
        rd(3'd6, 32'h0, "bus_adr6");
        rd(3'd1, 32'hA5, "bus_adr6_nochg");
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; sel = 4'b0001; dat_w = 32'h00;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        rd(3'd1, 32'hA5, "bus_abort_nowrite");

        // Reset in the middle of a MASK write
        src = 8'h01;
        tick();
        tick();
        probe(4'd1, "rst_pre_irq");
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; sel = 4'b0001; dat_w = 32'hFF;
        tick();
        rst = 1'b1;
        probe(4'd0, "rst_async_irq");
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        tick();
        rd(3'd1, NMI_BIT, "rst_mask_after");
        rd(3'd0, 32'h01, "rst_pending_level");
        rd(3'd2, 32'h00, "rst_mode_after");

        // Source 0 with mask clear and global enable off
        int_en = 1'b0;
        tick();
        probe(NMI_IRQ, "nmi_src0");
        src = 8'h00;
        tick();
        tick();

        checks++;
        if (bq_name.size() != 0 || pq_name.size() != 0) begin
            errors++;
            $display("FAIL leftover: bus=%0d probe=%0d expectations outstanding, required 0",
                     bq_name.size(), pq_name.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_intctrl.md
WB_INTCTRL -- requirements
Module: wb_intctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8: number of interrupt sources, 1..16.
REQ-002 SHALL have parameter VECW, default 4: width of the vector output.
REQ-003 SHALL have parameter VEC_BASE, default 1: vector of source 0; source i maps to VEC_BASE+i; VEC_BASE>=1; VEC_BASE+NSRC-1 <= 2^VECW-1.
REQ-004 SHALL have port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cyc_i, input, 1: Wishbone cycle.
REQ-007 SHALL have port stb_i, input, 1: Wishbone strobe (chip select).
REQ-008 SHALL have port we_i, input, 1: write enable.
REQ-009 SHALL have port adr_i, input, 3: word address.
REQ-010 SHALL have port sel_i, input, 4: byte lanes.
REQ-011 SHALL have port dat_i, input, 32: write data.
REQ-012 SHALL have port dat_o, output, 32: read data.
REQ-013 SHALL have port ack_o, output, 1: Wishbone acknowledge.
REQ-014 SHALL have port src_i, input, NSRC: interrupt sources, synchronous to clk_i, active-high.
REQ-015 SHALL have port int_en_i, input, 1: CPU global interrupt enable.
REQ-016 SHALL have port irq_o, output, VECW: vector to CPU; 0 = no interrupt.
REQ-017 SHALL have port irq_valid_o, output, 1: high iff irq_o != 0.

Function
REQ-018 SHALL decode registers by adr_i: 0 PENDING (R, write-1-to-clear); 1 MASK (RW, 1=enabled); 2 MODE (RW, 1=edge, 0=level); 3 VECTOR (R, current irq_o, zero-extended); 4 RAW (R, src_i); 5-7 read 0, writes ignored.
REQ-019 SHALL honour sel_i on writes per byte lane; bits >= NSRC read 0 and ignore writes.
REQ-020 SHALL assert ack_o the cycle after cyc_i&stb_i is first sampled high, for exactly one cycle per access; SHALL deassert ack_o immediately if cyc_i drops; a new access needs stb_i low or ack seen.
REQ-021 SHALL present dat_o valid in the ack_o cycle; dat_o = 0 otherwise.
REQ-022 SHALL register src_i every cycle (src_q) for edge detection.
REQ-023 Edge mode: SHALL set PENDING[i] on src_i[i] & ~src_q[i]; W1C clears it; set and clear in the same cycle -> set wins.
REQ-024 Level mode: PENDING[i] SHALL equal registered src_i[i]; W1C has no effect.
REQ-025 Mode change level->edge SHALL clear PENDING[i] that cycle; edge->level SHALL load the level next cycle.
REQ-026 Candidate set SHALL be PENDING & MASK; lowest index SHALL be highest priority.
REQ-027 irq_o SHALL be registered: VEC_BASE+i of the winning source, or 0 if no candidate or int_en_i low; latency one clk_i from PENDING/MASK/int_en_i change to irq_o.
REQ-028 MASK SHALL gate output only; masked sources SHALL still latch PENDING.
REQ-029 Vector arithmetic SHALL be VECW bits, no wrap by construction (REQ-003).

Reset
REQ-030 On rst_i high, asynchronously: PENDING=0, MASK=0, MODE=0 (level), src_q=0, irq_o=0, irq_valid_o=0, ack_o=0, dat_o=0.
REQ-031 Reset mid-access SHALL drop ack_o; the access is lost; no register is written.
REQ-032 After rst_i falls, first edge SHALL be detectable from the first clk_i (src_q=0 baseline).

Configuration
REQ-033 With INTCTRL_NMI_EN defined: source 0 SHALL be non-maskable: bypasses MASK and int_en_i, always highest priority; MASK[0] reads 1, writes ignored.
REQ-034 Without INTCTRL_NMI_EN: source 0 SHALL behave as any other source.

Verification
REQ-035 Level: NSRC=8, MASK=0xFF, int_en_i=1, raise src_i[3] -> PENDING=0x08, irq_o=4 two cycles later; drop src_i[3] -> irq_o=0 two cycles later.
REQ-036 Priority: MASK=0xFF, src_i=0x60 level -> irq_o=6; clear MASK[5] -> irq_o=7 next-but-one cycle; int_en_i=0 -> irq_o=0.
REQ-037 Edge W1C: MODE=0x01, 1-cycle pulse on src_i[0] -> PENDING=0x01, irq_o=1 held after pulse; write 0x01 to adr 0 -> PENDING=0, irq_o=0; second pulse coinciding with W1C -> PENDING stays 0x01.
REQ-038 Bus: read adr 1 after write 0xA5 with sel_i=0001 -> dat_o=0x000000A5, ack_o exactly one cycle; write to adr 6 -> ack, no state change; drop cyc_i before ack -> no ack, no write.
REQ-039 Reset: assert rst_i mid-write of MASK=0xFF with pending sources -> all outputs 0 asynchronously, MASK reads 0 after release.
REQ-040 NMI (INTCTRL_NMI_EN): MASK=0, int_en_i=0, src_i[0]=1 -> irq_o=1; without macro -> irq_o=0.
